// File: rtl/lif_neuron_pkg.sv
// Shared constants and the 7-segment lookup table for the LIF neuron tile.
package lif_neuron_pkg;

  localparam int unsigned V_W            = 8;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned CNT_MAX        = 9;
  localparam int unsigned SEG_W          = 7;
  localparam int unsigned DEFAULT_THRESH = 200;

  // Digit-indexed segment codes, bit0=a .. bit6=g, active-high; entry 0 is rightmost.
  localparam logic [CNT_MAX:0][SEG_W-1:0] SEG_LUT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/lif_neuron_if.sv
// Tile-harness pin bundle for the LIF neuron: enable, current/threshold inputs, display outputs.
interface lif_neuron_if;
  import lif_neuron_pkg::*;

  logic           ena;
  logic [V_W-1:0] ui_in;
  logic [V_W-1:0] uio_in;
  logic [V_W-1:0] uo_out;
  logic [V_W-1:0] uio_out;
  logic [V_W-1:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );

endinterface

// File: rtl/seg7_decoder.sv
// Spike-count digit to 7-segment code; digits above 9 blank the display.
module seg7_decoder
  import lif_neuron_pkg::*;
(
  input  logic [CNT_W-1:0] digit,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = '0;
    if (digit <= CNT_W'(CNT_MAX)) begin
      seg = SEG_LUT[digit];
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: 1/2 leak, subtractive reset, saturating potential,
// 0-9 spike counter shown on a 7-segment display. rst_n is active-high (harness name).
module lif_neuron #(
  parameter int unsigned DEFAULT_THRESH = lif_neuron_pkg::DEFAULT_THRESH
) (
  input  logic         clk,
  input  logic         rst_n,
  lif_neuron_if.slave  bus
);
  import lif_neuron_pkg::*;

  logic [V_W-1:0]   v;
  logic [V_W-1:0]   v_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [V_W-1:0]   teff;
  logic [V_W-1:0]   base;
  logic [V_W:0]     sum;
  logic             spike;
  logic [SEG_W-1:0] seg;

  // Threshold and spike are combinational so a threshold change shows in the same cycle.
  always_comb begin
    teff = (bus.uio_in == '0) ? V_W'(DEFAULT_THRESH) : bus.uio_in;
    spike = (v >= teff);
  end

  // Next-state: subtractive reset on spike, halve, add current, saturate at full scale.
  always_comb begin
    base     = v;
    v_next   = v;
    cnt_next = cnt;
    sum      = '0;
    if (bus.ena) begin
      base   = spike ? (v - teff) : v;
      sum    = (V_W + 1)'(bus.ui_in) + (V_W + 1)'(base >> 1);
      v_next = sum[V_W] ? '1 : sum[V_W-1:0];
      if (spike) begin
        cnt_next = (cnt == CNT_W'(CNT_MAX)) ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      v   <= '0;
      cnt <= '0;
    end else begin
      v   <= v_next;
      cnt <= cnt_next;
    end
  end

  seg7_decoder u_seg7 (
    .digit (cnt),
    .seg   (seg)
  );

  assign bus.uo_out  = {spike, seg};
  assign bus.uio_out = '0;
  assign bus.uio_oe  = '0;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron with hand-computed potentials and display codes.
module tb_lif_neuron;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  lif_neuron_if bus ();

  lif_neuron dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] seg_tab [10];
  logic [7:0] sub_v   [9];
  logic [7:0] per_v   [7];
  logic [7:0] per_uo  [7];

  initial begin
    checks = 0;
    passed = 0;
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    sub_v   = '{8'd100, 8'd150, 8'd175, 8'd187, 8'd193, 8'd196, 8'd198, 8'd199, 8'd199};
    per_v   = '{8'd120, 8'd180, 8'd210, 8'd125, 8'd182, 8'd211, 8'd125};
    per_uo  = '{8'h3F, 8'h3F, 8'hBF, 8'h06, 8'h06, 8'h86, 8'h5B};

    // Reset state
    rst_n      = 1'b1;
    bus.ena    = 1'b0;
    bus.ui_in  = 8'd0;
    bus.uio_in = 8'd200;
    #1;
    check("reset_uo", bus.uo_out, 8'h3F);
    check("reset_uio_out", bus.uio_out, 8'h00);
    check("reset_uio_oe", bus.uio_oe, 8'h00);
    tick();
    tick();
    rst_n = 1'b0;

    // Sub-threshold approach to 199, never spiking
    bus.ena   = 1'b1;
    bus.ui_in = 8'd100;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("sub_v[%0d]", i), dut.v, sub_v[i]);
      check($sformatf("sub_uo[%0d]", i), bus.uo_out, 8'h3F);
    end

    // Clear back to V=0 before the firing run
    rst_n = 1'b1;
    #1;
    check("rst_clear_v", dut.v, 8'd0);
    rst_n = 1'b0;

    // Periodic firing with period 3
    bus.ui_in = 8'd120;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("per_v[%0d]", i), dut.v, per_v[i]);
      check($sformatf("per_uo[%0d]", i), bus.uo_out, per_uo[i]);
    end

    // Enable hold: state frozen even with a different current applied
    bus.ena   = 1'b0;
    bus.ui_in = 8'd255;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_v[%0d]", i), dut.v, 8'd125);
      check($sformatf("hold_uo[%0d]", i), bus.uo_out, 8'h5B);
    end
    bus.ui_in = 8'd120;
    bus.ena   = 1'b1;
    tick();
    check("resume_v0", dut.v, 8'd182);
    check("resume_uo0", bus.uo_out, 8'h5B);
    tick();
    check("resume_v1", dut.v, 8'd211);
    check("resume_uo1", bus.uo_out, 8'hDB);
    tick();
    check("resume_v2", dut.v, 8'd125);
    check("resume_uo2", bus.uo_out, 8'h4F);

    // Threshold change acts on the spike bit within the same cycle
    bus.uio_in = 8'd100;
    #1;
    check("thresh_low_uo", bus.uo_out, 8'hCF);
    bus.uio_in = 8'd200;
    #1;
    check("thresh_back_uo", bus.uo_out, 8'h4F);

    // Asynchronous reset mid-run with count 3 and V=125, before any edge
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst_uo", bus.uo_out, 8'h3F);
    check("async_rst_v", dut.v, 8'd0);
    tick();
    rst_n     = 1'b0;
    bus.ui_in = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_v[%0d]", i), dut.v, 8'd0);
      check($sformatf("idle_uo[%0d]", i), bus.uo_out, 8'h3F);
    end

    // Default threshold, saturation, and counter wrap 9 -> 0
    bus.uio_in = 8'd0;
    bus.ui_in  = 8'd255;
    tick();
    check("dflt_v0", dut.v, 8'd255);
    check("dflt_uo0", bus.uo_out, 8'hBF);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("dflt_v[%0d]", k), dut.v, 8'd255);
      check($sformatf("dflt_uo[%0d]", k), bus.uo_out, 8'h80 | seg_tab[k % 10]);
    end

    // Threshold 255 with V=255: equality spikes every cycle
    bus.uio_in = 8'd255;
    #1;
    check("eq_uo0", bus.uo_out, 8'hBF);
    tick();
    check("eq_v1", dut.v, 8'd255);
    check("eq_uo1", bus.uo_out, 8'h86);
    tick();
    check("eq_uo2", bus.uo_out, 8'hDB);
    check("eq_uio_out", bus.uio_out, 8'h00);
    check("eq_uio_oe", bus.uio_oe, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
